// File: rtl/elevator_ctrl.sv
// elevator_ctrl: single-car, 8-floor elevator controller.
// Floor requests are queued in arrival order; the car steps one floor per
// clock toward the oldest outstanding request and pops it on arrival.
module elevator_ctrl #(
  parameter int QUEUE_DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_button_pressed,
  input  logic [2:0] i_button_value,
  output logic [2:0] o_floor
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(QUEUE_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    MOVING_UP,
    MOVING_DOWN
  } state_e;

  logic [2:0]    mem_q [QUEUE_DEPTH];
  logic [2:0]    mem_d [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    floor_q, floor_d;

  state_e     state;
  logic       pop;
  logic       push;
  logic       empty;
  logic       full;
  logic [2:0] head;
  logic [2:0] second;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH_C);
  assign head   = mem_q[rd_ptr_q];
  assign second = mem_q[next_ptr(rd_ptr_q)];

  // Motion decode from queue contents before this edge's enqueue; on arrival
  // the head is popped and the direction comes from the entry behind it.
  always_comb begin
    state = IDLE;
    pop   = 1'b0;
    if (!empty) begin
      if (floor_q != head) begin
        state = (head > floor_q) ? MOVING_UP : MOVING_DOWN;
      end else begin
        pop = 1'b1;
        if ((count_q > CW'(1)) && (second != floor_q)) begin
          state = (second > floor_q) ? MOVING_UP : MOVING_DOWN;
        end
      end
    end
  end

  // Next floor, queue pointers, occupancy and storage.
  always_comb begin
    floor_d  = floor_q;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    push     = i_button_pressed && (!full || pop);

    unique case (state)
      MOVING_UP:   floor_d = floor_q + 3'd1;
      MOVING_DOWN: floor_d = floor_q - 3'd1;
      default:     floor_d = floor_q;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = i_button_value;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      floor_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      floor_q  <= floor_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Floor output straight from its register.
  always_comb begin
    o_floor = floor_q;
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl: table-driven per-edge vectors with a
// scoreboard queue, plus hand-built full-queue and async-reset sequences.
module tb_elevator_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_button_pressed = 1'b0;
  logic [2:0] i_button_value = '0;
  logic [2:0] o_floor;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       p;
    logic [2:0] v;
    logic [2:0] e;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] sb[$];

  elevator_ctrl #(.QUEUE_DEPTH(8)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_button_pressed (i_button_pressed),
    .i_button_value   (i_button_value),
    .o_floor          (o_floor)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: o_floor=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic p, input logic [2:0] v, input logic [2:0] e);
    vec_t r;
    r.p = p; r.v = v; r.e = e;
    vecs.push_back(r);
  endtask

  // Drive one edge's inputs, queue its expected floor, compare after the edge.
  task automatic cycle(input logic p, input logic [2:0] v, input logic [2:0] e,
                       input string name);
    logic [2:0] exp;
    i_button_pressed = p;
    i_button_value   = v;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    exp = sb.pop_front();
    check(name, o_floor, exp);
    i_button_pressed = 1'b0;
  endtask

  initial begin
    logic [2:0] qord [16];
    logic [2:0] targets [9];
    logic [2:0] fpress [10];
    logic [2:0] trace [$];
    logic [2:0] f;

    // Queued-order scenario, edges 1..20 after reset release.
    qord = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
             3'd5, 3'd4, 3'd3, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
    for (int n = 1; n <= 20; n++) begin
      logic       p;
      logic [2:0] v;
      logic [2:0] e;
      p = 1'b0; v = 3'd0;
      if (n == 3)  begin p = 1'b1; v = 3'd7; end
      if (n == 7)  begin p = 1'b1; v = 3'd2; end
      if (n == 9)  begin p = 1'b1; v = 3'd4; end
      if (n == 14) begin p = 1'b1; v = 3'd5; end
      if (n <= 3)       e = 3'd0;
      else if (n <= 19) e = qord[n-4];
      else              e = 3'd5;
      add(p, v, e);
    end
    // Return to ground from floor 5.
    add(1'b1, 3'd0, 3'd5);
    add(1'b0, 3'd0, 3'd4); add(1'b0, 3'd0, 3'd3); add(1'b0, 3'd0, 3'd2);
    add(1'b0, 3'd0, 3'd1); add(1'b0, 3'd0, 3'd0);
    add(1'b0, 3'd0, 3'd0); add(1'b0, 3'd0, 3'd0);
    // Single trip 0 -> 7.
    add(1'b1, 3'd7, 3'd0);
    for (int k = 1; k <= 7; k++) add(1'b0, 3'd0, 3'(k));
    add(1'b0, 3'd0, 3'd7); add(1'b0, 3'd0, 3'd7);
    // Self-request at floor 7 with empty queue.
    add(1'b1, 3'd7, 3'd7);
    add(1'b0, 3'd0, 3'd7); add(1'b0, 3'd0, 3'd7); add(1'b0, 3'd0, 3'd7);

    // Reset behaviour.
    #1;
    check("reset_async", o_floor, 3'd0);
    @(posedge i_clk); @(posedge i_clk); #1;
    check("reset_held", o_floor, 3'd0);
    i_rst = 1'b0;

    foreach (vecs[i]) begin
      cycle(vecs[i].p, vecs[i].v, vecs[i].e, $sformatf("vec%0d", i));
    end

    // Full queue from floor 7: eight presses fill it, the ninth lands on a
    // pop edge and is kept, the tenth arrives while full and is dropped.
    fpress  = '{3'd0, 3'd7, 3'd0, 3'd7, 3'd0, 3'd7, 3'd0, 3'd7, 3'd3, 3'd5};
    targets = '{3'd0, 3'd7, 3'd0, 3'd7, 3'd0, 3'd7, 3'd0, 3'd7, 3'd3};
    f = 3'd7;
    trace.push_back(f);
    foreach (targets[t]) begin
      while (f != targets[t]) begin
        f = (targets[t] > f) ? f + 3'd1 : f - 3'd1;
        trace.push_back(f);
      end
    end
    for (int k = 0; k < 4; k++) trace.push_back(f);
    foreach (trace[i]) begin
      if (i < 10) cycle(1'b1, fpress[i], trace[i], $sformatf("full%0d", i));
      else        cycle(1'b0, 3'd0,      trace[i], $sformatf("full%0d", i));
    end

    // Async reset while travelling 2 -> 6.
    cycle(1'b1, 3'd2, 3'd3, "rst_seq0");
    cycle(1'b0, 3'd0, 3'd2, "rst_seq1");
    cycle(1'b1, 3'd6, 3'd2, "rst_seq2");
    cycle(1'b0, 3'd0, 3'd3, "rst_seq3");
    cycle(1'b0, 3'd0, 3'd4, "rst_seq4");
    #2;
    i_rst = 1'b1;
    #1;
    check("rst_mid_travel", o_floor, 3'd0);
    #3;
    i_rst = 1'b0;
    for (int k = 0; k < 5; k++) cycle(1'b0, 3'd0, 3'd0, $sformatf("rst_after%0d", k));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
